// File: rtl/game_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : game_pkg                                                    |
// | Desc   : Shared constants, state encoding and helpers for the game   |
// |          drawing blocks (ball, paddle, bricks).                      |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package game_pkg;

  localparam int COLOUR_W      = 3;
  localparam int H_RES_DEFAULT = 640;
  localparam int V_RES_DEFAULT = 480;

  // Offset counters cover shapes up to 16x16 pixels
  localparam int CNT_W  = 4;
  localparam int SIZE_W = 5;

  localparam logic [COLOUR_W-1:0] BLACK = 3'b000;
  localparam logic [COLOUR_W-1:0] WHITE = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } draw_state_t;

  // A coordinate sum is on screen when it is strictly below the limit
  function automatic logic on_screen(input logic [10:0] coord, input logic [10:0] lim);
    return (coord < lim);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ball_draw_square_scan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : square_scan                                                 |
// | Desc   : Free-running 2-D offset counter walking a size x size       |
// |          square in row-major order. start restarts at (0,0).         |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module square_scan
  import game_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [SIZE_W-1:0] size,
  output logic [CNT_W-1:0]  cx,
  output logic [CNT_W-1:0]  cy,
  output logic              last
);

  logic [SIZE_W-1:0] size_m1;
  logic              row_end;
  logic              col_end;

  assign size_m1 = size - SIZE_W'(1);
  assign row_end = ({1'b0, cx} == size_m1);
  assign col_end = ({1'b0, cy} == size_m1);
  assign last    = row_end && col_end;

  // Advance one slot per clock; wrap x into the next row, wrap the square
  always_ff @(posedge clk) begin
    if (reset || start) begin
      cx <= '0;
      cy <= '0;
    end else if (row_end) begin
      cx <= '0;
      cy <= col_end ? '0 : cy + CNT_W'(1);
    end else begin
      cx <= cx + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/ball_draw.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ball_draw                                                   |
// | Desc   : Erases the ball square at its previous position and redraws |
// |          it at the new one, one frame-buffer pixel write per clock.  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module ball_draw
  import game_pkg::*;
#(
  parameter int                  BALL_SIZE   = 4,
  parameter logic [COLOUR_W-1:0] BALL_COLOUR = WHITE,
  parameter logic [COLOUR_W-1:0] BG_COLOUR   = BLACK,
  parameter int                  H_RES       = H_RES_DEFAULT,
  parameter int                  V_RES       = V_RES_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [9:0]          X,
  input  logic [9:0]          Y,
  input  logic                pos_valid,
  output logic [9:0]          vga_x,
  output logic [9:0]          vga_y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  localparam logic [SIZE_W-1:0] SIZE    = SIZE_W'(BALL_SIZE);
  localparam logic [SIZE_W-1:0] SIZE_M1 = SIZE_W'(BALL_SIZE - 1);
  localparam logic [10:0]       H_LIM   = 11'(H_RES);
  localparam logic [10:0]       V_LIM   = 11'(V_RES);

  draw_state_t          state;
  logic [9:0]           new_x, new_y;
  logic [9:0]           old_x, old_y;
  logic                 old_valid;

  logic [CNT_W-1:0]     cx, cy;
  logic                 last;
  logic                 accept;
  logic                 scan_start;

  logic [CNT_W-1:0]     nxt_cx, nxt_cy;
  logic [9:0]           base_x, base_y;
  logic [CNT_W-1:0]     off_x, off_y;
  logic [COLOUR_W-1:0]  sel_colour;
  logic                 emit;
  logic [10:0]          sum_x, sum_y;

  assign accept     = (state == IDLE) && pos_valid;
  assign scan_start = accept || ((state == ERASE) && last);

  square_scan u_scan (
    .clk   (clk),
    .reset (reset),
    .start (scan_start),
    .size  (SIZE),
    .cx    (cx),
    .cy    (cy),
    .last  (last)
  );

  // Offset of the slot following the one currently on the outputs
  always_comb begin
    nxt_cx = cx + CNT_W'(1);
    nxt_cy = cy;
    if ({1'b0, cx} == SIZE_M1) begin
      nxt_cx = '0;
      nxt_cy = cy + CNT_W'(1);
    end
  end

  // Choose the pixel to present after the next edge: the outputs run one
  // slot ahead of the counter so the first pixel follows pos_valid directly
  always_comb begin
    base_x     = old_x;
    base_y     = old_y;
    off_x      = '0;
    off_y      = '0;
    sel_colour = BG_COLOUR;
    emit       = 1'b0;
    case (state)
      IDLE: begin
        emit = pos_valid;
        if (!old_valid) begin
          base_x     = X;
          base_y     = Y;
          sel_colour = BALL_COLOUR;
        end
      end
      ERASE: begin
        emit = 1'b1;
        if (last) begin
          base_x     = new_x;
          base_y     = new_y;
          sel_colour = BALL_COLOUR;
        end else begin
          off_x = nxt_cx;
          off_y = nxt_cy;
        end
      end
      DRAW: begin
        emit       = !last;
        base_x     = new_x;
        base_y     = new_y;
        off_x      = nxt_cx;
        off_y      = nxt_cy;
        sel_colour = BALL_COLOUR;
      end
      default: begin
        emit = 1'b0;
      end
    endcase
  end

  // Sums are kept 11 bits wide so positions near 1023 clip rather than wrap
  assign sum_x = {1'b0, base_x} + {{(11-CNT_W){1'b0}}, off_x};
  assign sum_y = {1'b0, base_y} + {{(11-CNT_W){1'b0}}, off_y};

  // Sequencer with registered pixel-port outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      plot      <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      vga_x     <= '0;
      vga_y     <= '0;
      colour    <= BG_COLOUR;
      new_x     <= '0;
      new_y     <= '0;
      old_x     <= '0;
      old_y     <= '0;
      old_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      if (emit) begin
        vga_x  <= sum_x[9:0];
        vga_y  <= sum_y[9:0];
        colour <= sel_colour;
        plot   <= on_screen(sum_x, H_LIM) && on_screen(sum_y, V_LIM);
      end else begin
        plot <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            new_x <= X;
            new_y <= Y;
            busy  <= 1'b1;
            state <= old_valid ? ERASE : DRAW;
          end
        end
        ERASE: begin
          if (last) begin
            state <= DRAW;
          end
        end
        DRAW: begin
          if (last) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        default: begin
          old_x     <= new_x;
          old_y     <= new_y;
          old_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ball_draw.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_ball_draw                                                |
// | Desc   : Self-checking bench for ball_draw with a per-cycle          |
// |          expected-output queue built from the drawing rules.         |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_ball_draw;

  localparam int S     = 4;
  localparam int HRES  = 640;
  localparam int VRES  = 480;
  localparam logic [2:0] BALL = 3'b111;
  localparam logic [2:0] BG   = 3'b000;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] px, py;
  logic       pos_valid;
  logic [9:0] vga_x, vga_y;
  logic [2:0] colour;
  logic       plot, busy, done;

  ball_draw #(
    .BALL_SIZE   (S),
    .BALL_COLOUR (BALL),
    .BG_COLOUR   (BG),
    .H_RES       (HRES),
    .V_RES       (VRES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .X         (px),
    .Y         (py),
    .pos_valid (pos_valid),
    .vga_x     (vga_x),
    .vga_y     (vga_y),
    .colour    (colour),
    .plot      (plot),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         pix;
    bit         plot;
    bit         busy;
    bit         done;
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] col;
  } rec_t;

  rec_t       exp_q[$];
  bit         m_old_valid;
  logic [9:0] m_old_x, m_old_y;
  bit         expect_rst;
  bit         cur_idle;

  int checks = 0;
  int passed = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs === expv) passed++;
    else $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, expv);
  endtask

  // Append one pass over a square: row-major, clipped slots keep their cycle
  task automatic push_square(input logic [9:0] bx, input logic [9:0] by, input logic [2:0] col);
    rec_t r;
    int sx, sy;
    for (int j = 0; j < S; j++) begin
      for (int i = 0; i < S; i++) begin
        sx     = int'(bx) + i;
        sy     = int'(by) + j;
        r.pix  = 1'b1;
        r.plot = (sx < HRES) && (sy < VRES);
        r.busy = 1'b1;
        r.done = 1'b0;
        r.x    = sx[9:0];
        r.y    = sy[9:0];
        r.col  = col;
        exp_q.push_back(r);
      end
    end
  endtask

  task automatic build(input logic [9:0] nx, input logic [9:0] ny);
    rec_t r;
    if (m_old_valid) push_square(m_old_x, m_old_y, BG);
    push_square(nx, ny, BALL);
    r.pix = 1'b0; r.plot = 1'b0; r.busy = 1'b1; r.done = 1'b1;
    r.x = '0; r.y = '0; r.col = '0;
    exp_q.push_back(r);
    m_old_x     = nx;
    m_old_y     = ny;
    m_old_valid = 1'b1;
  endtask

  task automatic check_cycle();
    rec_t r;
    if (expect_rst) begin
      check_val("rst_plot", plot, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_done", done, 0);
      check_val("rst_x", vga_x, 0);
      check_val("rst_y", vga_y, 0);
      check_val("rst_col", colour, BG);
      cur_idle = 1'b1;
    end else if (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      check_val("plot", plot, r.plot);
      check_val("busy", busy, r.busy);
      check_val("done", done, r.done);
      if (r.pix) begin
        check_val("vga_x", vga_x, r.x);
        check_val("vga_y", vga_y, r.y);
        check_val("colour", colour, r.col);
      end
      cur_idle = 1'b0;
    end else begin
      check_val("idle_plot", plot, 0);
      check_val("idle_busy", busy, 0);
      check_val("idle_done", done, 0);
      cur_idle = 1'b1;
    end
  endtask

  // Check the current cycle, then drive inputs for the next edge and update the model
  task automatic step(input logic pv, input logic [9:0] nx, input logic [9:0] ny, input logic rst);
    check_cycle();
    reset     = rst;
    pos_valid = pv;
    px        = nx;
    py        = ny;
    if (rst) begin
      exp_q.delete();
      m_old_valid = 1'b0;
      expect_rst  = 1'b1;
    end else begin
      expect_rst = 1'b0;
      if (pv && cur_idle) build(nx, ny);
    end
    @(negedge clk);
  endtask

  task automatic idle_n(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 10'd0, 10'd0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; pos_valid = 1'b0; px = '0; py = '0;
    m_old_valid = 1'b0; m_old_x = '0; m_old_y = '0;
    cur_idle = 1'b1;
    repeat (2) @(negedge clk);
    expect_rst = 1'b1;
    step(1'b0, 10'd0, 10'd0, 1'b0);

    // First draw, then a moving update with erase
    step(1'b1, 10'd100, 10'd50, 1'b0);
    idle_n(20);
    step(1'b1, 10'd101, 10'd51, 1'b0);
    idle_n(36);

    // Clipping at the bottom-right corner on a first draw
    step(1'b0, 10'd0, 10'd0, 1'b1);
    step(1'b1, 10'd638, 10'd478, 1'b0);
    idle_n(20);

    // Request during an update is dropped
    step(1'b1, 10'd300, 10'd300, 1'b0);
    idle_n(4);
    step(1'b1, 10'd10, 10'd10, 1'b0);
    idle_n(30);

    // Reset in the middle of an erase, then a draw-only update
    step(1'b1, 10'd50, 10'd60, 1'b0);
    idle_n(9);
    step(1'b0, 10'd0, 10'd0, 1'b1);
    step(1'b1, 10'd70, 10'd70, 1'b0);
    idle_n(20);

    // Same position twice still erases and redraws
    step(1'b1, 10'd200, 10'd200, 1'b0);
    idle_n(20);
    step(1'b1, 10'd200, 10'd200, 1'b0);
    idle_n(36);

    // Randomised traffic including near-1023 coordinates and stray resets
    for (int c = 0; c < 3000; c++) begin
      logic [9:0] rx, ry;
      rx = ($urandom_range(0, 15) == 0) ? 10'($urandom_range(1018, 1023)) : 10'($urandom_range(0, 660));
      ry = ($urandom_range(0, 15) == 0) ? 10'($urandom_range(1018, 1023)) : 10'($urandom_range(0, 500));
      if ($urandom_range(0, 499) == 0) step(1'b0, 10'd0, 10'd0, 1'b1);
      else step(($urandom_range(0, 7) == 0), rx, ry, 1'b0);
    end
    idle_n(40);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
